// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares the single memory-mapped data bus between two masters
//   (port 0 = CPU data port, port 1 = DMA/debug master). One transaction
//   runs at a time: a grant in IDLE, an ACCESS window of WAIT_STATES+1
//   cycles, then a one-cycle ACK back to the winning master. Ties are
//   broken round-robin against the previous winner.
//
// Ports
//   core_clock, reset          clock (rising edge) and async active-high reset
//   m0_req/we/addr/be/wdata    master 0 request; held until m0_ack
//   m0_ack, m0_rdata           master 0 completion pulse and registered read data
//   m1_*                       identical set for master 1
//   bus_address/wdata/be       shared bus drivers (DAddress/DWriteData/DByteEnable)
//   bus_re, bus_we             read enable / write strobe
//   bus_rdata                  read data returned by the peripherals
//   grant                      one-hot owner of the current transaction
//   busy                       high while in ACCESS or ACK
module data_bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                core_clock,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   bus_address,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  output logic                bus_re,
  output logic                bus_we,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t state, state_next;

  logic              last;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        counter;

  logic start;
  logic win;

  // The counter is loaded with WAIT_STATES on grant, so the first ACCESS
  // cycle is the one where it still holds that value.
  logic first_access;
  assign first_access = (counter == 4'(WAIT_STATES));

  // The bus address and write data simply follow the latched request; only
  // the strobes and byte enables are qualified by state.
  assign bus_address = lat_addr;
  assign bus_wdata   = lat_wdata;

  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. Strobes are pure functions of the state
  // register so an asynchronous reset removes them in the same cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    win        = 1'b0;
    bus_re     = 1'b0;
    bus_we     = 1'b0;
    bus_be     = '0;
    grant      = 2'b00;
    busy       = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          start      = 1'b1;
          // On a tie the master that did not win last time goes next.
          win        = (m0_req && m1_req) ? ~last : m1_req;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        grant  = owner ? 2'b10 : 2'b01;
        bus_be = lat_be;
        bus_re = ~lat_we;
        bus_we = lat_we & first_access;
        if (counter == 4'd0) begin
          state_next = ACK;
        end
      end
      ACK: begin
        busy       = 1'b1;
        grant      = owner ? 2'b10 : 2'b01;
        m0_ack     = ~owner;
        m1_ack     = owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latching, wait-state counting and read-data capture. Master
  // inputs are only looked at on the grant, so they may change freely
  // while the transaction is in flight.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      counter   <= 4'd0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else if (start) begin
      owner     <= win;
      last      <= win;
      lat_we    <= win ? m1_we    : m0_we;
      lat_addr  <= win ? m1_addr  : m0_addr;
      lat_be    <= win ? m1_be    : m0_be;
      lat_wdata <= win ? m1_wdata : m0_wdata;
      counter   <= 4'(WAIT_STATES);
    end else if (state == ACCESS) begin
      if (counter != 4'd0) begin
        counter <= counter - 4'd1;
      end else if (!lat_we) begin
        if (owner) begin
          m1_rdata <= bus_rdata;
        end else begin
          m0_rdata <= bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter. A WAIT_STATES=1 instance carries
// most of the checks; a WAIT_STATES=0 instance shares the same master and
// bus inputs and is checked for the single-cycle access case.
module tb_data_bus_arbiter;

  logic        core_clock;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] bus_rdata;

  logic        m0_ack, m1_ack, bus_re, bus_we, busy;
  logic [31:0] m0_rdata, m1_rdata, bus_address, bus_wdata;
  logic [3:0]  bus_be;
  logic [1:0]  grant;

  logic        z_m0_ack, z_m1_ack, z_bus_re, z_bus_we, z_busy;
  logic [31:0] z_m0_rdata, z_m1_rdata, z_bus_address, z_bus_wdata;
  logic [3:0]  z_bus_be;
  logic [1:0]  z_grant;

  int num_checks;
  int num_fail;
  logic [31:0] exp_m0_rdata;
  logic [31:0] exp_m1_rdata;

  data_bus_arbiter #(.WAIT_STATES(1), .ADDR_W(32), .DATA_W(32)) u_dut (
    .core_clock(core_clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_re(bus_re), .bus_we(bus_we), .bus_rdata(bus_rdata),
    .grant(grant), .busy(busy)
  );

  data_bus_arbiter #(.WAIT_STATES(0), .ADDR_W(32), .DATA_W(32)) u_dut_ws0 (
    .core_clock(core_clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
    .bus_address(z_bus_address), .bus_wdata(z_bus_wdata), .bus_be(z_bus_be),
    .bus_re(z_bus_re), .bus_we(z_bus_we), .bus_rdata(bus_rdata),
    .grant(z_grant), .busy(z_busy)
  );

  initial core_clock = 1'b0;
  always #5 core_clock = ~core_clock;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one master's request bundle.
  task automatic applyStimulus(input int which, input logic req, input logic we,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
    if (which == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge core_clock);
    #1;
  endtask

  initial begin
    num_checks   = 0;
    num_fail     = 0;
    exp_m0_rdata = 32'h0;
    exp_m1_rdata = 32'h0;
    reset        = 1'b1;
    bus_rdata    = 32'h0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    #2;
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_bus_re", bus_re, 1'b0);
    checkOutput("rst_bus_we", bus_we, 1'b0);
    checkOutput("rst_acks", {m0_ack, m1_ack}, 2'b00);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
    checkOutput("rst_bus_address", bus_address, 32'h0);
    stepCycle();
    reset = 1'b0;
    stepCycle();

    $display("[TB] reset during a write access");
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hAAAA_5555);
    stepCycle();
    checkOutput("t1_we_before_reset", bus_we, 1'b1);
    checkOutput("t1_grant_before_reset", grant, 2'b01);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t1_async_bus_we", bus_we, 1'b0);
    checkOutput("t1_async_bus_re", bus_re, 1'b0);
    checkOutput("t1_async_grant", grant, 2'b00);
    checkOutput("t1_async_busy", busy, 1'b0);
    checkOutput("t1_async_acks", {m0_ack, m1_ack}, 2'b00);
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0024, 4'hF, 32'h0);
    stepCycle();
    checkOutput("t1_m0_wins_after_reset", grant, 2'b01);
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stepCycle();
    reset = 1'b0;
    stepCycle();

    $display("[TB] master 0 read");
    bus_rdata = 32'hBAD0_BAD0;
    applyStimulus(0, 1'b1, 1'b0, 32'hFF20_0000, 4'hF, 32'h0);
    stepCycle();
    checkOutput("t2_grant", grant, 2'b01);
    checkOutput("t2_busy", busy, 1'b1);
    checkOutput("t2_re_c1", bus_re, 1'b1);
    checkOutput("t2_we_c1", bus_we, 1'b0);
    checkOutput("t2_address", bus_address, 32'hFF20_0000);
    checkOutput("t2_ack_c1", m0_ack, 1'b0);
    bus_rdata = 32'h1234_5678;
    stepCycle();
    checkOutput("t2_re_c2", bus_re, 1'b1);
    checkOutput("t2_ack_c2", m0_ack, 1'b0);
    stepCycle();
    exp_m0_rdata = 32'h1234_5678;
    checkOutput("t2_m0_ack", m0_ack, 1'b1);
    checkOutput("t2_m1_ack", m1_ack, 1'b0);
    checkOutput("t2_re_ack", bus_re, 1'b0);
    checkOutput("t2_be_ack", bus_be, 4'h0);
    checkOutput("t2_grant_ack", grant, 2'b01);
    checkOutput("t2_m0_rdata", m0_rdata, exp_m0_rdata);
    checkOutput("t2_m1_rdata", m1_rdata, exp_m1_rdata);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stepCycle();
    checkOutput("t2_ack_drop", m0_ack, 1'b0);
    checkOutput("t2_idle_busy", busy, 1'b0);
    checkOutput("t2_idle_grant", grant, 2'b00);

    $display("[TB] master 1 write");
    applyStimulus(1, 1'b1, 1'b1, 32'h1001_0004, 4'b0011, 32'hDEAD_BEEF);
    stepCycle();
    checkOutput("t3_grant", grant, 2'b10);
    checkOutput("t3_we_c1", bus_we, 1'b1);
    checkOutput("t3_re_c1", bus_re, 1'b0);
    checkOutput("t3_be_c1", bus_be, 4'b0011);
    checkOutput("t3_address", bus_address, 32'h1001_0004);
    checkOutput("t3_wdata", bus_wdata, 32'hDEAD_BEEF);
    stepCycle();
    checkOutput("t3_we_c2", bus_we, 1'b0);
    checkOutput("t3_re_c2", bus_re, 1'b0);
    checkOutput("t3_be_c2", bus_be, 4'b0011);
    checkOutput("t3_ack_c2", m1_ack, 1'b0);
    stepCycle();
    checkOutput("t3_m1_ack", m1_ack, 1'b1);
    checkOutput("t3_m0_ack", m0_ack, 1'b0);
    checkOutput("t3_be_ack", bus_be, 4'h0);
    checkOutput("t3_m1_rdata", m1_rdata, exp_m1_rdata);
    checkOutput("t3_m0_rdata", m0_rdata, exp_m0_rdata);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stepCycle();
    checkOutput("t3_idle_busy", busy, 1'b0);

    $display("[TB] continuous requests from both masters");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      bus_rdata = 32'hC0DE_0000 + 32'(k);
      stepCycle();
      checkOutput($sformatf("t4_grant_%0d", k), grant, (k % 2 == 1) ? 2'b10 : 2'b01);
      stepCycle();
      stepCycle();
      if (k % 2 == 1) exp_m1_rdata = 32'hC0DE_0000 + 32'(k);
      else            exp_m0_rdata = 32'hC0DE_0000 + 32'(k);
      checkOutput($sformatf("t4_m0_ack_%0d", k), m0_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
      checkOutput($sformatf("t4_m1_ack_%0d", k), m1_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
      checkOutput($sformatf("t4_m0_rdata_%0d", k), m0_rdata, exp_m0_rdata);
      checkOutput($sformatf("t4_m1_rdata_%0d", k), m1_rdata, exp_m1_rdata);
      stepCycle();
      checkOutput($sformatf("t4_idle_%0d", k), busy, 1'b0);
      if (k == 5) begin
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
    end
    stepCycle();

    $display("[TB] master 1 drops request mid-access");
    applyStimulus(1, 1'b1, 1'b1, 32'h2000_0008, 4'b1100, 32'h0BAD_F00D);
    stepCycle();
    checkOutput("t5_grant", grant, 2'b10);
    checkOutput("t5_we_c1", bus_we, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 32'h3000_0000, 4'hF, 32'h1111_1111);
    stepCycle();
    checkOutput("t5_address_held", bus_address, 32'h2000_0008);
    checkOutput("t5_wdata_held", bus_wdata, 32'h0BAD_F00D);
    checkOutput("t5_be_held", bus_be, 4'b1100);
    checkOutput("t5_re_still_write", bus_re, 1'b0);
    checkOutput("t5_we_c2", bus_we, 1'b0);
    stepCycle();
    checkOutput("t5_m1_ack", m1_ack, 1'b1);
    checkOutput("t5_m0_ack", m0_ack, 1'b0);
    checkOutput("t5_m1_rdata", m1_rdata, exp_m1_rdata);
    checkOutput("t5_m0_rdata", m0_rdata, exp_m0_rdata);
    stepCycle();
    checkOutput("t5_ack_drop", m1_ack, 1'b0);

    $display("[TB] zero wait states");
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    bus_rdata = 32'h5A5A_A5A5;
    applyStimulus(0, 1'b1, 1'b0, 32'h4000_0000, 4'hF, 32'h0);
    stepCycle();
    checkOutput("t6_re_c1", z_bus_re, 1'b1);
    checkOutput("t6_grant_rd", z_grant, 2'b01);
    checkOutput("t6_ack_rd_c1", z_m0_ack, 1'b0);
    stepCycle();
    checkOutput("t6_m0_ack", z_m0_ack, 1'b1);
    checkOutput("t6_re_ack", z_bus_re, 1'b0);
    checkOutput("t6_m0_rdata", z_m0_rdata, 32'h5A5A_A5A5);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stepCycle();
    checkOutput("t6_idle_rd", z_busy, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 32'h4000_0004, 4'b0011, 32'hCAFE_0001);
    stepCycle();
    checkOutput("t6_we_c1", z_bus_we, 1'b1);
    checkOutput("t6_grant_wr", z_grant, 2'b10);
    checkOutput("t6_wdata", z_bus_wdata, 32'hCAFE_0001);
    stepCycle();
    checkOutput("t6_m1_ack", z_m1_ack, 1'b1);
    checkOutput("t6_we_ack", z_bus_we, 1'b0);
    checkOutput("t6_m1_rdata", z_m1_rdata, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stepCycle();
    checkOutput("t6_idle_wr", z_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
